// File: rtl/ode_pkg.sv
// Memory map, dimension limit and state types shared by the ODE host loader.
package ode_pkg;
  localparam int MAX_DIM   = 50;
  localparam int N_ADD     = 0;
  localparam int M_ADD     = 1;
  localparam int H_ADD     = 4;
  localparam int A_BASE    = 7;
  localparam int B_BASE    = 2507;
  localparam int X_BASE    = 5207;
  localparam int U_BASE    = 5257;
  localparam int XNEW_BASE = 5407;

  typedef enum logic [3:0] {
    IDLE, HDR, LOAD_A, LOAD_B, LOAD_X, LOAD_U, INIT, RUN, DRAIN
  } state_t;

  typedef enum logic [1:0] {D_ISSUE, D_CAPT, D_SHOW} drain_ph_t;
endpackage

// File: rtl/ode_host_loader.sv
// Host front end for the Euler ODE solver: loads the problem into solver RAM,
// sequences INT/PROCESS/DONE and streams the XNew vector back out.
//
// state  | meaning
// IDLE   | ready for n; INT/PROCESS low
// HDR    | accepting m (validated), then h
// LOAD_A | A matrix words, n x n
// LOAD_B | B matrix words, n x m
// LOAD_X | X vector words, n
// LOAD_U | U vector words, m
// INIT   | INT=1 PROCESS=0 for INIT_CYCLES
// RUN    | INT=1 PROCESS=1 until DONE or timeout
// DRAIN  | read XNew and present it on the output stream
module ode_host_loader #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int MAX_DIM       = ode_pkg::MAX_DIM,
  parameter int INIT_CYCLES   = 4,
  parameter int TIMEOUT       = 65535
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     ram_enable_wr,
  output logic [ADDRESS_WIDTH-1:0] ram_add_wr,
  output logic [DATA_WIDTH-1:0]    ram_data_wr,
  output logic [ADDRESS_WIDTH-1:0] ram_add_rd,
  input  logic [DATA_WIDTH-1:0]    ram_data_rd,
  output logic                     solver_int,
  output logic                     solver_process,
  input  logic                     done,
  output logic                     busy,
  output logic                     err
);
  import ode_pkg::*;

  localparam int TMAX = (TIMEOUT > INIT_CYCLES) ? TIMEOUT : INIT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  state_t                   state, state_nxt;
  drain_ph_t                dph_q;
  logic [15:0]              n_q, m_q, row_q, col_q, col_lim;
  logic [ADDRESS_WIDTH-1:0] addr_q, next_base, wr_addr;
  logic [TW-1:0]            tmr_q;
  logic                     accept, hdr_m, bad_hdr, col_last, row_last, sec_end;
  logic                     wr_en, k_last;

  assign accept   = in_valid & in_ready;
  assign hdr_m    = (state == HDR) && (col_q == 16'd0);
  assign bad_hdr  = (n_q == 16'd0) || (n_q > 16'(MAX_DIM)) ||
                    (in_data[15:0] == 16'd0) || (in_data[15:0] > 16'(MAX_DIM));
  assign col_last = (col_q == col_lim - 16'd1);
  assign row_last = (row_q == n_q - 16'd1);
  assign sec_end  = col_last && (row_last || state == LOAD_X || state == LOAD_U);
  assign k_last   = (col_q == n_q - 16'd1);
  assign wr_en    = accept && !(hdr_m && bad_hdr);

  always_comb begin
    col_lim   = n_q;
    next_base = addr_q;
    case (state)
      LOAD_A:  next_base = ADDRESS_WIDTH'(B_BASE);
      LOAD_B:  begin col_lim = m_q; next_base = ADDRESS_WIDTH'(X_BASE); end
      LOAD_X:  next_base = ADDRESS_WIDTH'(U_BASE);
      LOAD_U:  col_lim = m_q;
      default: ;
    endcase
  end

  assign wr_addr = (state == IDLE) ? ADDRESS_WIDTH'(N_ADD) :
                   (state == HDR)  ? ((col_q == 16'd0) ? ADDRESS_WIDTH'(M_ADD)
                                                       : ADDRESS_WIDTH'(H_ADD)) :
                   addr_q;

  assign ram_enable_wr  = wr_en;
  assign ram_add_wr     = wr_en ? wr_addr : '0;
  assign ram_data_wr    = wr_en ? in_data : '0;
  assign busy           = (state != IDLE);
  assign solver_int     = (state == INIT) || (state == RUN);
  assign solver_process = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (accept) state_nxt = HDR;
      HDR:    if (accept) begin
                if (!hdr_m)       state_nxt = LOAD_A;
                else if (bad_hdr) state_nxt = IDLE;
              end
      LOAD_A: if (accept && sec_end) state_nxt = LOAD_B;
      LOAD_B: if (accept && sec_end) state_nxt = LOAD_X;
      LOAD_X: if (accept && sec_end) state_nxt = LOAD_U;
      LOAD_U: if (accept && sec_end) state_nxt = INIT;
      INIT:   if (tmr_q == '0) state_nxt = RUN;
      RUN:    if (done) state_nxt = DRAIN;
              else if (tmr_q == '0) state_nxt = IDLE;
      DRAIN:  if (dph_q == D_SHOW && out_ready && k_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      ram_add_rd <= '0;
      err        <= 1'b0;
      n_q        <= '0;
      m_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      tmr_q      <= '0;
      dph_q      <= D_ISSUE;
    end else begin
      in_ready <= state_nxt inside {IDLE, HDR, LOAD_A, LOAD_B, LOAD_X, LOAD_U};
      case (state)
        IDLE: if (accept) begin
          n_q   <= in_data[15:0];
          err   <= 1'b0;
          col_q <= '0;
        end
        HDR: if (accept) begin
          if (!hdr_m) begin
            addr_q <= ADDRESS_WIDTH'(A_BASE);
            row_q  <= '0;
            col_q  <= '0;
          end else if (bad_hdr) begin
            err <= 1'b1;
          end else begin
            m_q   <= in_data[15:0];
            col_q <= 16'd1;
          end
        end
        LOAD_A, LOAD_B, LOAD_X, LOAD_U: if (accept) begin
          if (col_last) begin
            col_q <= '0;
            row_q <= row_q + 16'd1;
          end else begin
            col_q <= col_q + 16'd1;
          end
          // Sections are contiguous, so the running address only jumps at section ends.
          if (sec_end) begin
            row_q  <= '0;
            addr_q <= next_base;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
          if (state == LOAD_U) tmr_q <= TW'(INIT_CYCLES - 1);
        end
        INIT: begin
          if (tmr_q == '0) tmr_q <= TW'(TIMEOUT - 1);
          else             tmr_q <= tmr_q - 1'b1;
        end
        RUN: begin
          if (done) begin
            ram_add_rd <= ADDRESS_WIDTH'(XNEW_BASE);
            col_q      <= '0;
            dph_q      <= D_ISSUE;
          end else if (tmr_q == '0) begin
            err <= 1'b1;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        DRAIN: begin
          case (dph_q)
            D_ISSUE: dph_q <= D_CAPT;
            D_CAPT: begin
              out_data  <= ram_data_rd;
              out_valid <= 1'b1;
              dph_q     <= D_SHOW;
              // Prefetch the next element while this one waits for the sink.
              if (!k_last) ram_add_rd <= ram_add_rd + 1'b1;
            end
            D_SHOW: if (out_ready) begin
              out_valid <= 1'b0;
              col_q     <= col_q + 16'd1;
              dph_q     <= D_CAPT;
            end
            default: dph_q <= D_ISSUE;
          endcase
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ode_host_loader.sv
// Directed bench for ode_host_loader: table-driven load vectors plus
// hand-written sequences for init/run timing, drain, header errors, reset and timeout.
module tb_ode_host_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data, ram_data_wr, ram_data_rd;
  logic [12:0] ram_add_wr, ram_add_rd;
  logic        ram_enable_wr, solver_int, solver_process, done, busy, err;
  logic        solver_en;
  int          pcnt = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct { logic [63:0] data; logic [12:0] addr; } wr_vec_t;
  typedef struct { logic [63:0] n; logic [63:0] m; } hdr_vec_t;
  wr_vec_t  vec[12];
  hdr_vec_t hv[4];
  logic [63:0] mem [0:8191];

  always #5 clk = ~clk;

  ode_host_loader #(.TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_enable_wr(ram_enable_wr), .ram_add_wr(ram_add_wr), .ram_data_wr(ram_data_wr),
    .ram_add_rd(ram_add_rd), .ram_data_rd(ram_data_rd),
    .solver_int(solver_int), .solver_process(solver_process), .done(done),
    .busy(busy), .err(err)
  );

  // XNew contents encode their own address so a skipped or stale read shows up.
  function automatic logic [63:0] xnew(input int a);
    return 64'hA5A5_0000_0000_0000 + 64'(a);
  endfunction

  always @(posedge clk) begin
    if (ram_enable_wr) mem[ram_add_wr] <= ram_data_wr;
    ram_data_rd <= (ram_add_rd >= 13'd5407) ? xnew(int'(ram_add_rd)) : mem[ram_add_rd];
  end

  always @(posedge clk) pcnt <= solver_process ? pcnt + 1 : 0;
  assign done = solver_en && solver_process && (pcnt == 20);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input int upto);
    for (int i = 0; i < upto; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vec[i].data;
      #1;
      check("in_ready", 64'(in_ready), 64'd1);
      check("wr_en", 64'(ram_enable_wr), 64'd1);
      check("wr_addr", 64'(ram_add_wr), 64'(vec[i].addr));
      check("wr_data", ram_data_wr, vec[i].data);
    end
  endtask

  task automatic run_phase(input int exp_cnt, input logic exp_done);
    int cnt;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 64'hDEAD;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("init_int", 64'(solver_int), 64'd1);
      check("init_process", 64'(solver_process), 64'd0);
      check("init_in_ready", 64'(in_ready), 64'd0);
      check("init_no_write", 64'(ram_enable_wr), 64'd0);
      @(negedge clk);
      #1;
    end
    in_valid = 1'b0;
    cnt = 0;
    while (solver_process === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    check("run_cycles", 64'(cnt), 64'(exp_cnt));
    check("post_run_int", 64'(solver_int), 64'd0);
    check("post_run_process", 64'(solver_process), 64'd0);
    check("post_run_busy", 64'(busy), exp_done ? 64'd1 : 64'd0);
    check("post_run_err", 64'(err), exp_done ? 64'd0 : 64'd1);
  endtask

  task automatic drain(input int n, input int stall);
    int got, cyc, since;
    got = 0; cyc = 0; since = -1;
    while (got < n && cyc < 300) begin
      @(negedge clk);
      if (since >= 0) since++;
      out_ready = !(since >= 1 && since <= stall);
      #1;
      if (out_valid) begin
        check("out_data", out_data, xnew(5407 + got));
        if (out_ready) begin
          got++;
          since = 0;
        end
      end
      cyc++;
    end
    check("drain_count", 64'(got), 64'(n));
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("drain_idle_busy", 64'(busy), 64'd0);
    check("drain_idle_valid", 64'(out_valid), 64'd0);
    check("drain_idle_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    vec[0]  = '{64'd2, 13'd0};    vec[1]  = '{64'd1, 13'd1};
    vec[2]  = '{64'd3, 13'd4};    vec[3]  = '{64'd1, 13'd7};
    vec[4]  = '{64'd2, 13'd8};    vec[5]  = '{64'd3, 13'd9};
    vec[6]  = '{64'd4, 13'd10};   vec[7]  = '{64'd5, 13'd2507};
    vec[8]  = '{64'd6, 13'd2508}; vec[9]  = '{64'd7, 13'd5207};
    vec[10] = '{64'd8, 13'd5208}; vec[11] = '{64'd9, 13'd5257};
    hv[0] = '{64'd0, 64'd1};  hv[1] = '{64'd51, 64'd1};
    hv[2] = '{64'd2, 64'd0};  hv[3] = '{64'd2, 64'd51};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; solver_en = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b1; in_data = 64'h55;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_wr_en", 64'(ram_enable_wr), 64'd0);
    check("rst_wr_addr", 64'(ram_add_wr), 64'd0);
    check("rst_wr_data", ram_data_wr, 64'd0);
    check("rst_rd_addr", 64'(ram_add_rd), 64'd0);
    check("rst_int", 64'(solver_int), 64'd0);
    check("rst_process", 64'(solver_process), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("release_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    #1;
    check("release_ready_high", 64'(in_ready), 64'd1);

    // Basic load, init/run timing and drain
    load(12);
    run_phase(21, 1'b1);
    check("mem_n", mem[0], 64'd2);
    check("mem_b1", mem[2508], 64'd6);
    check("mem_u0", mem[5257], 64'd9);
    drain(2, 0);

    // Illegal headers
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = hv[i].n;
      #1;
      check("hdr_n_wr_en", 64'(ram_enable_wr), 64'd1);
      check("hdr_n_addr", 64'(ram_add_wr), 64'd0);
      @(negedge clk);
      in_data = hv[i].m;
      #1;
      check("hdr_err_cleared", 64'(err), 64'd0);
      check("hdr_m_no_write", 64'(ram_enable_wr), 64'd0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("hdr_err_set", 64'(err), 64'd1);
      check("hdr_idle", 64'(busy), 64'd0);
      check("hdr_ready", 64'(in_ready), 64'd1);
    end

    // Output backpressure mid-drain
    load(12);
    run_phase(21, 1'b1);
    drain(2, 10);

    // Reset asserted while a B word is on the bus
    load(8);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", 64'(ram_enable_wr), 64'd0);
    check("mid_rst_wr_addr", 64'(ram_add_wr), 64'd0);
    check("mid_rst_wr_data", ram_data_wr, 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_int", 64'(solver_int), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_idle", 64'(busy), 64'd0);
    check("post_rst_ready", 64'(in_ready), 64'd1);
    load(12);
    run_phase(21, 1'b1);
    drain(2, 0);

    // Solver never answers
    solver_en = 1'b0;
    load(12);
    run_phase(100, 1'b0);
    check("timeout_ready", 64'(in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
